// File: rtl/spi_txn_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : spi_txn_arbiter
// Purpose  : Round-robin arbiter that shares one SPI master engine among
//            NREQ requesters. It grants one requester at a time, drives that
//            requester's chip select, programs the master's mode and tx byte,
//            launches the transfer, waits for completion and returns the
//            received byte with a one-cycle done pulse. All chip selects are
//            held high for a guard gap between transfers.
// Revision : 1.0 - initial release
// ============================================================================
module spi_txn_arbiter #(
    parameter int NREQ      = 4,
    parameter int DW        = 8,
    parameter int GUARD_CYC = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ-1:0]    req_cpol,
    input  logic [NREQ-1:0]    req_cpha,
    input  logic [NREQ*DW-1:0] req_data,
    output logic [NREQ-1:0]    gnt,
    output logic [NREQ-1:0]    done,
    output logic [DW-1:0]      rx_data,
    output logic [NREQ-1:0]    cs_n,
    output logic               m_start,
    output logic               m_cpol,
    output logic               m_cpha,
    output logic [DW-1:0]      m_tx_data,
    input  logic               m_ready,
    input  logic [DW-1:0]      m_rx_data
);

    // Pointer width (at least one bit so a single-requester build still works)
    localparam int PW    = (NREQ > 1) ? $clog2(NREQ) : 1;
    // Guard counter width and terminal count; GUARD state is unused at 0
    localparam int GW    = (GUARD_CYC > 1) ? $clog2(GUARD_CYC) : 1;
    localparam int GLAST = (GUARD_CYC > 0) ? GUARD_CYC - 1 : 0;

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_SETUP     = 3'd1;
    localparam logic [2:0] S_LAUNCH    = 3'd2;
    localparam logic [2:0] S_WAIT_BUSY = 3'd3;
    localparam logic [2:0] S_WAIT_DONE = 3'd4;
    localparam logic [2:0] S_GUARD     = 3'd5;

    // ------------------------------------------------------------------------
    // State and registered outputs
    // ------------------------------------------------------------------------
    logic [2:0]      state_q,  state_d;
    logic [PW-1:0]   ptr_q,    ptr_d;
    logic [GW-1:0]   guard_q,  guard_d;
    logic [NREQ-1:0] gnt_q,    gnt_d;
    logic [NREQ-1:0] done_q,   done_d;
    logic [NREQ-1:0] cs_n_q,   cs_n_d;
    logic [DW-1:0]   rx_q,     rx_d;
    logic            start_q,  start_d;
    logic            cpol_q,   cpol_d;
    logic            cpha_q,   cpha_d;
    logic [DW-1:0]   tx_q,     tx_d;

    // ------------------------------------------------------------------------
    // Round-robin selection
    // ------------------------------------------------------------------------
    logic            sel_found;
    logic [PW-1:0]   sel_idx;
    logic [NREQ-1:0] sel_oh;
    logic            sel_cpol;
    logic            sel_cpha;
    logic [DW-1:0]   sel_data;

    // Find the first active request after the last-served requester, wrapping
    always_comb begin
        int          cand;
        logic [PW-1:0] cand_idx;
        cand      = 0;
        cand_idx  = '0;
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand     = (int'(ptr_q) + k) % NREQ;
            cand_idx = PW'(cand);
            if (!sel_found && req[cand_idx]) begin
                sel_found = 1'b1;
                sel_idx   = cand_idx;
            end
        end
    end

    // Decode the winner to one-hot and mux out its mode and tx byte
    always_comb begin
        sel_oh   = '0;
        sel_cpol = 1'b0;
        sel_cpha = 1'b0;
        sel_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (sel_idx == PW'(i)) begin
                sel_oh[i] = 1'b1;
                sel_cpol  = req_cpol[i];
                sel_cpha  = req_cpha[i];
                sel_data  = req_data[i*DW +: DW];
            end
        end
    end

    // ------------------------------------------------------------------------
    // Transaction sequencer: next-state and next-output logic
    // ------------------------------------------------------------------------
    // Mode/data registers only load in IDLE so the master sees a stable
    // configuration for the whole time a chip select is low.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        guard_d = guard_q;
        gnt_d   = gnt_q;
        cs_n_d  = cs_n_q;
        rx_d    = rx_q;
        cpol_d  = cpol_q;
        cpha_d  = cpha_q;
        tx_d    = tx_q;
        done_d  = '0;
        start_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (sel_found) begin
                    gnt_d   = sel_oh;
                    cs_n_d  = ~sel_oh;
                    cpol_d  = sel_cpol;
                    cpha_d  = sel_cpha;
                    tx_d    = sel_data;
                    ptr_d   = sel_idx;
                    state_d = S_SETUP;
                end
            end

            // At least one cycle here lets sclk settle to the new polarity
            S_SETUP: begin
                if (m_ready) begin
                    start_d = 1'b1;
                    state_d = S_LAUNCH;
                end
            end

            S_LAUNCH: begin
                state_d = S_WAIT_BUSY;
            end

            // Wait for the master to acknowledge the launch by going busy
            S_WAIT_BUSY: begin
                if (!m_ready) begin
                    state_d = S_WAIT_DONE;
                end
            end

            S_WAIT_DONE: begin
                if (m_ready) begin
                    rx_d    = m_rx_data;
                    done_d  = gnt_q;
                    gnt_d   = '0;
                    cs_n_d  = '1;
                    guard_d = '0;
                    state_d = (GUARD_CYC == 0) ? S_IDLE : S_GUARD;
                end
            end

            // Chip selects stay high; requests are not looked at here
            S_GUARD: begin
                if (guard_q == GW'(GLAST)) begin
                    guard_d = '0;
                    state_d = S_IDLE;
                end else begin
                    guard_d = guard_q + GW'(1);
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Register all state; reset abandons any transfer without a done pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            ptr_q   <= PW'(NREQ - 1);
            guard_q <= '0;
            gnt_q   <= '0;
            done_q  <= '0;
            cs_n_q  <= '1;
            rx_q    <= '0;
            start_q <= 1'b0;
            cpol_q  <= 1'b0;
            cpha_q  <= 1'b0;
            tx_q    <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            guard_q <= guard_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            cs_n_q  <= cs_n_d;
            rx_q    <= rx_d;
            start_q <= start_d;
            cpol_q  <= cpol_d;
            cpha_q  <= cpha_d;
            tx_q    <= tx_d;
        end
    end

    assign gnt       = gnt_q;
    assign done      = done_q;
    assign rx_data   = rx_q;
    assign cs_n      = cs_n_q;
    assign m_start   = start_q;
    assign m_cpol    = cpol_q;
    assign m_cpha    = cpha_q;
    assign m_tx_data = tx_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_txn_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_txn_arbiter
// Purpose  : Self-checking bench for spi_txn_arbiter with a behavioural SPI
//            master model and a round-robin reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_txn_arbiter;

    localparam int NREQ  = 4;
    localparam int DW    = 8;
    localparam int GUARD = 2;

    logic        clk;
    logic        rst;
    logic [3:0]  req, req_cpol, req_cpha;
    logic [31:0] req_data;
    logic [3:0]  gnt, done, cs_n;
    logic [7:0]  rx_data, m_tx_data, m_rx_data;
    logic        m_start, m_cpol, m_cpha, m_ready;

    // Second instance with no guard gap
    logic [3:0]  z_req, z_gnt, z_done, z_cs_n;
    logic [7:0]  z_rx_data, z_m_tx_data, z_m_rx_data;
    logic        z_m_start, z_m_cpol, z_m_cpha, z_m_ready;

    spi_txn_arbiter #(.NREQ(NREQ), .DW(DW), .GUARD_CYC(GUARD)) dut (
        .clk(clk), .rst(rst), .req(req), .req_cpol(req_cpol), .req_cpha(req_cpha),
        .req_data(req_data), .gnt(gnt), .done(done), .rx_data(rx_data), .cs_n(cs_n),
        .m_start(m_start), .m_cpol(m_cpol), .m_cpha(m_cpha), .m_tx_data(m_tx_data),
        .m_ready(m_ready), .m_rx_data(m_rx_data)
    );

    spi_txn_arbiter #(.NREQ(NREQ), .DW(DW), .GUARD_CYC(0)) dut_z (
        .clk(clk), .rst(rst), .req(z_req), .req_cpol(4'b0000), .req_cpha(4'b0000),
        .req_data(32'h1234_5678), .gnt(z_gnt), .done(z_done), .rx_data(z_rx_data),
        .cs_n(z_cs_n), .m_start(z_m_start), .m_cpol(z_m_cpol), .m_cpha(z_m_cpha),
        .m_tx_data(z_m_tx_data), .m_ready(z_m_ready), .m_rx_data(z_m_rx_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ------------------------------------------------------------------------
    // Behavioural SPI master: goes busy the cycle after m_start, stays busy
    // busy_len cycles, then returns a byte and goes ready.
    // ------------------------------------------------------------------------
    int         mst_busy    = 0;
    bit         mst_launch  = 0;
    int         busy_len    = 8;
    bit         ready_block = 0;
    bit         use_force   = 0;
    logic [7:0] rx_force    = 8'h00;
    logic [7:0] last_rx     = 8'h00;

    initial begin
        m_ready   = 1'b1;
        m_rx_data = 8'h00;
        forever begin
            @(negedge clk);
            if (mst_busy > 0) begin
                mst_busy--;
                if (mst_busy == 0) m_rx_data = last_rx;
            end else if (mst_launch) begin
                mst_launch = 0;
                mst_busy   = busy_len;
                last_rx    = use_force ? rx_force : 8'($urandom);
            end
            if (m_start === 1'b1) mst_launch = 1;
            m_ready = (mst_busy == 0) && !ready_block;
        end
    end

    int zbusy = 0;
    bit zl    = 0;
    initial begin
        z_m_ready   = 1'b1;
        z_m_rx_data = 8'h00;
        forever begin
            @(negedge clk);
            if (zbusy > 0) begin
                zbusy--;
                if (zbusy == 0) z_m_rx_data = z_m_rx_data + 8'h11;
            end else if (zl) begin
                zl    = 0;
                zbusy = 3;
            end
            if (z_m_start === 1'b1) zl = 1;
            z_m_ready = (zbusy == 0);
        end
    end

    // ------------------------------------------------------------------------
    // Monitor: records grants and completions, checks per-cycle invariants
    // ------------------------------------------------------------------------
    typedef struct {
        int         idx;
        logic [7:0] tx;
        logic       pol;
        logic       pha;
        int         gap;
    } grec_t;

    grec_t      gq[$];
    int         dq[$];
    grec_t      cur;
    int         cyc           = 0;
    int         last_done_cyc = -1000;
    int         mstart_cnt    = 0;
    logic [3:0] prev_gnt      = 4'h0;
    logic [3:0] prev_done     = 4'h0;

    function automatic int oh2i(input logic [3:0] v);
        for (int i = 0; i < 4; i++) if (v[i]) return i;
        return -1;
    endfunction

    initial begin
        logic [3:0] inv_gnt;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (rst) begin
                prev_gnt      = 4'h0;
                prev_done     = 4'h0;
                last_done_cyc = -1000;
            end else begin
                inv_gnt = ~gnt;
                chk("cs_n_matches_gnt", cs_n, inv_gnt);
                chk("gnt_onehot0", $onehot0(gnt), 1);
                if (m_start === 1'b1) begin
                    mstart_cnt++;
                    chk("start_while_ready", m_ready, 1);
                end
                if (gnt != 0 && prev_gnt == 0) begin
                    cur.idx = oh2i(gnt);
                    cur.tx  = m_tx_data;
                    cur.pol = m_cpol;
                    cur.pha = m_cpha;
                    cur.gap = cyc - last_done_cyc;
                    gq.push_back(cur);
                    chk("grant_gap_min", (cur.gap >= GUARD + 1), 1);
                end else if (gnt != 0) begin
                    chk("gnt_hold", gnt, prev_gnt);
                    chk("cfg_stable", {m_cpol, m_cpha, m_tx_data}, {cur.pol, cur.pha, cur.tx});
                end
                if (prev_done != 0) chk("done_one_cycle", done, 0);
                if (done != 0) begin
                    chk("done_to_granted", done, prev_gnt);
                    chk("done_rx", rx_data, last_rx);
                    chk("done_cs_high", cs_n, 4'hF);
                    dq.push_back(oh2i(done));
                    last_done_cyc = cyc;
                end
                prev_gnt  = gnt;
                prev_done = done;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Reference model: next winner is the first requester after the last
    // served one, going around the ring.
    // ------------------------------------------------------------------------
    int mptr;

    function automatic int pick(input logic [3:0] mask, input int ptr);
        for (int off = 1; off <= 4; off++) begin
            if (mask[(ptr + off) % 4]) return (ptr + off) % 4;
        end
        return -1;
    endfunction

    task automatic rand_cfg();
        logic [7:0] base;
        base     = 8'($urandom);
        req_data = {base + 8'h9F, base + 8'h6A, base + 8'h35, base};
        req_cpol = 4'($urandom);
        req_cpha = 4'($urandom);
        busy_len = $urandom_range(2, 10);
    endtask

    // Hold a request mask until n completions, then compare against the model
    task automatic run_held(input logic [3:0] mask, input int n, input string tag);
        int t;
        int e;
        gq.delete();
        dq.delete();
        @(negedge clk);
        req = mask;
        t   = 0;
        while (dq.size() < n && t < n * 300) begin
            @(negedge clk);
            t++;
        end
        req = 4'h0;
        chk({tag, "_ndone"}, dq.size(), n);
        repeat (GUARD + 4) @(negedge clk);
        chk({tag, "_ngrant"}, gq.size(), n);
        for (int k = 0; k < n && k < gq.size(); k++) begin
            e = pick(mask, mptr);
            chk({tag, "_idx"}, gq[k].idx, e);
            chk({tag, "_tx"}, gq[k].tx, req_data[e*8 +: 8]);
            chk({tag, "_cpol"}, gq[k].pol, req_cpol[e]);
            chk({tag, "_cpha"}, gq[k].pha, req_cpha[e]);
            if (k < dq.size()) chk({tag, "_done_idx"}, dq[k], e);
            if (k > 0) chk({tag, "_gap"}, gq[k].gap, GUARD + 1);
            mptr = e;
        end
    endtask

    // ------------------------------------------------------------------------
    // Directed and randomized stimulus
    // ------------------------------------------------------------------------
    initial begin
        int t;
        int s0;
        rst      = 1'b1;
        req      = 4'h0;
        req_cpol = 4'h0;
        req_cpha = 4'h0;
        req_data = 32'h0;
        z_req    = 4'h0;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_gnt", gnt, 0);
        chk("rst_done", done, 0);
        chk("rst_rx", rx_data, 0);
        chk("rst_cs_n", cs_n, 4'hF);
        chk("rst_m_start", m_start, 0);
        chk("rst_m_cpol", m_cpol, 0);
        chk("rst_m_cpha", m_cpha, 0);
        chk("rst_m_tx", m_tx_data, 0);
        rst  = 1'b0;
        mptr = 3;

        // Single transfer
        req_cpol  = 4'b0001;
        req_cpha  = 4'b0001;
        req_data  = 32'h0000_00AA;
        busy_len  = 64;
        use_force = 1;
        rx_force  = 8'h55;
        req       = 4'b0001;
        @(negedge clk);
        chk("t1_gnt", gnt, 4'b0001);
        chk("t1_cs_n", cs_n, 4'b1110);
        chk("t1_cpol", m_cpol, 1);
        chk("t1_cpha", m_cpha, 1);
        chk("t1_tx", m_tx_data, 8'hAA);
        s0 = mstart_cnt;
        t  = 0;
        while (done == 0 && t < 200) begin @(negedge clk); t++; end
        chk("t1_done", done, 4'b0001);
        chk("t1_rx", rx_data, 8'h55);
        chk("t1_start_once", mstart_cnt - s0, 1);
        @(negedge clk);
        chk("t1_done_pulse", done, 0);
        chk("t1_guard_gnt_a", gnt, 0);
        chk("t1_guard_cs_a", cs_n, 4'hF);
        @(negedge clk);
        chk("t1_guard_gnt_b", gnt, 0);
        chk("t1_guard_cs_b", cs_n, 4'hF);
        @(negedge clk);
        chk("t1_regrant", gnt, 4'b0001);
        req = 4'h0;
        t   = 0;
        while (done == 0 && t < 200) begin @(negedge clk); t++; end
        chk("t1_second_done", done, 4'b0001);
        use_force = 0;
        mptr      = 0;
        repeat (4) @(negedge clk);

        // Round-robin from a fresh reset: expected order 0,1,3,0,1
        rst = 1'b1;
        @(negedge clk);
        rst  = 1'b0;
        mptr = 3;
        rand_cfg();
        run_held(4'b1011, 5, "rr");

        // Config latching during requester 1's transfer
        req_data[15:8] = 8'h3C;
        req_cpha[1]    = 1'b0;
        busy_len       = 8;
        gq.delete();
        dq.delete();
        @(negedge clk);
        req = 4'b0010;
        t   = 0;
        while (m_ready == 1'b1 && t < 50) begin @(negedge clk); t++; end
        repeat (2) @(negedge clk);
        req_data[15:8] = 8'hFF;
        req_cpha[1]    = 1'b1;
        t = 0;
        while (dq.size() < 2 && t < 200) begin @(negedge clk); t++; end
        req = 4'h0;
        chk("t3_ngrant", gq.size(), 2);
        chk("t3_first_tx", gq[0].tx, 8'h3C);
        chk("t3_first_cpha", gq[0].pha, 0);
        chk("t3_second_tx", gq[1].tx, 8'hFF);
        chk("t3_second_cpha", gq[1].pha, 1);
        chk("t3_second_idx", gq[1].idx, 1);
        mptr = 1;
        repeat (6) @(negedge clk);

        // Master not ready after grant
        ready_block = 1;
        repeat (2) @(negedge clk);
        req = 4'b0100;
        t   = 0;
        while (gnt == 0 && t < 10) begin @(negedge clk); t++; end
        chk("t4_gnt", gnt, 4'b0100);
        s0 = mstart_cnt;
        repeat (10) begin
            @(negedge clk);
            chk("t4_no_start", m_start, 0);
        end
        ready_block = 0;
        t = 0;
        while (done == 0 && t < 200) begin @(negedge clk); t++; end
        req = 4'h0;
        chk("t4_done", done, 4'b0100);
        chk("t4_start_once", mstart_cnt - s0, 1);
        mptr = 2;
        repeat (6) @(negedge clk);

        // Drop request during WAIT_BUSY: completion still reported
        req = 4'b0100;
        t   = 0;
        while (m_start == 1'b0 && t < 50) begin @(negedge clk); t++; end
        @(negedge clk);
        req = 4'h0;
        t   = 0;
        while (done == 0 && t < 200) begin @(negedge clk); t++; end
        chk("t5_done_after_drop", done, 4'b0100);
        repeat (6) @(negedge clk);

        // Reset during WAIT_DONE
        busy_len = 20;
        req      = 4'b0001;
        t        = 0;
        while (m_ready == 1'b1 && t < 50) begin @(negedge clk); t++; end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        req = 4'h0;
        @(negedge clk);
        chk("t5_rst_cs_n", cs_n, 4'hF);
        chk("t5_rst_gnt", gnt, 0);
        chk("t5_rst_done", done, 0);
        chk("t5_rst_rx", rx_data, 0);
        rst  = 1'b0;
        mptr = 3;
        run_held(4'b1011, 3, "post_rst");

        // Randomized rounds
        for (int r = 0; r < 8; r++) begin
            rand_cfg();
            run_held(4'($urandom_range(1, 15)), $urandom_range(1, 5), "rnd");
        end

        // No guard gap: next grant one cycle after done
        @(negedge clk);
        z_req = 4'b0011;
        t     = 0;
        while (z_done == 0 && t < 50) begin @(negedge clk); t++; end
        chk("z_done0", z_done, 4'b0001);
        chk("z_rx0", z_rx_data, z_m_rx_data);
        chk("z_gnt_at_done", z_gnt, 0);
        z_req = 4'b0010;
        @(negedge clk);
        chk("z_regrant_1cyc", z_gnt, 4'b0010);
        t = 0;
        while (z_done == 0 && t < 50) begin @(negedge clk); t++; end
        chk("z_done1", z_done, 4'b0010);
        z_req = 4'h0;
        repeat (4) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
